// File: rtl/ieee_fx_pkg.sv
// Shared definitions for the IEEE-754 single <-> fixed-point bridge:
// FSM encoding, float format constants and field accessors.
package ieee_fx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TO_FIX,
        CORE_START,
        CORE_WAIT,
        TO_FLT,
        DONE
    } state_t;

    localparam int          BIAS  = 127;
    localparam int          EXP_W = 8;
    localparam int          MAN_W = 23;
    localparam logic [31:0] QNAN  = 32'h7FC0_0000;

    function automatic logic f_sign(input logic [31:0] f);
        return f[31];
    endfunction

    function automatic logic [EXP_W-1:0] f_exp(input logic [31:0] f);
        return f[30:23];
    endfunction

    function automatic logic [MAN_W-1:0] f_frac(input logic [31:0] f);
        return f[22:0];
    endfunction

endpackage

// File: rtl/fx_to_ieee.sv
// Combinational signed fixed-point to IEEE-754 single normaliser with
// round-to-nearest-even; exact whenever the magnitude fits in 24 bits.
module fx_to_ieee
    import ieee_fx_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic [WIDTH-1:0] fx,
    output logic [31:0]      flt
);

    localparam int P_W = $clog2(WIDTH);

    logic             sign;
    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] norm;
    logic [WIDTH-1:0] rest;
    logic [P_W-1:0]   p;
    logic [EXP_W-1:0] exp_b;
    logic [MAN_W-1:0] man;
    logic             guard;
    logic             sticky;
    logic             round_up;
    logic [30:0]      body;

    always_comb begin
        sign = fx[WIDTH-1];
        // Two's complement negate keeps the most negative word as 2^(WIDTH-1).
        mag  = sign ? (~fx + 1'b1) : fx;
        p    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (mag[i]) p = P_W'(i);
        end
        norm     = mag << (P_W'(WIDTH - 1) - p);
        man      = norm[WIDTH-2 -: MAN_W];
        rest     = norm << (MAN_W + 1);
        guard    = rest[WIDTH-1];
        sticky   = |rest[WIDTH-2:0];
        round_up = guard & (sticky | man[0]);
        exp_b    = EXP_W'(int'(p) - FRAC_BITS + BIAS);
        // A mantissa carry-out ripples straight into the exponent field.
        body     = {exp_b, man} + 31'(round_up);
        flt      = (fx == '0) ? 32'h0 : {sign, body};
    end

endmodule

// File: rtl/ieee_fx_bridge.sv
// Float front/back end for the fixed-point CORDIC core: one operand in,
// NCH float results out, with a core-hang timeout.
module ieee_fx_bridge
    import ieee_fx_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 16,
    parameter int NCH       = 3,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          in_x,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     core_x,
    output logic                 core_en,
    input  logic [NCH*WIDTH-1:0] core_res,
    input  logic                 core_valid,
    output logic [NCH*32-1:0]    out_z,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sat,
    output logic                 out_err
);

    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TMO_W = $clog2(TIMEOUT);

    state_t               state;
    logic [31:0]          x_reg;
    logic [NCH*WIDTH-1:0] res_reg;
    logic [CH_W-1:0]      ch_idx;
    logic [TMO_W-1:0]     tmo_cnt;

    logic [EXP_W-1:0]     xe;
    logic [MAN_W:0]       xm;
    int                   sh;
    logic [WIDTH-1:0]     fmag;
    logic [WIDTH-1:0]     fix_val;
    logic                 fix_sat;
    logic [WIDTH-1:0]     cur_fx;
    logic [31:0]          cur_flt;

    // Float to fixed: pure exponent shift of the 24-bit significand, truncating.
    always_comb begin
        xe      = f_exp(x_reg);
        xm      = {1'b1, f_frac(x_reg)};
        sh      = int'(xe) - BIAS + FRAC_BITS - MAN_W;
        fmag    = '0;
        fix_sat = 1'b0;
        fix_val = '0;
        if (sh >= 0) fmag = WIDTH'(xm) << sh;
        else         fmag = WIDTH'(xm >> (-sh));
        if (xe == '0) begin
            fix_val = '0;
        end else if (xe == '1 || (int'(xe) - BIAS) >= (WIDTH - 1 - FRAC_BITS)) begin
            fix_sat = 1'b1;
            fix_val = f_sign(x_reg) ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            fix_val = f_sign(x_reg) ? (~fmag + 1'b1) : fmag;
        end
    end

    assign cur_fx = res_reg[int'(ch_idx)*WIDTH +: WIDTH];

    fx_to_ieee #(
        .WIDTH     (WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_norm (
        .fx  (cur_fx),
        .flt (cur_flt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            core_en   <= 1'b0;
            core_x    <= '0;
            out_valid <= 1'b0;
            out_z     <= '0;
            out_sat   <= 1'b0;
            out_err   <= 1'b0;
            tmo_cnt   <= '0;
            ch_idx    <= '0;
            x_reg     <= '0;
            res_reg   <= '0;
        end else begin
            core_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_reg    <= in_x;
                        out_sat  <= 1'b0;
                        out_err  <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= TO_FIX;
                    end
                end
                TO_FIX: begin
                    core_x  <= fix_val;
                    out_sat <= fix_sat;
                    core_en <= 1'b1;
                    state   <= CORE_START;
                end
                CORE_START: begin
                    tmo_cnt <= '0;
                    state   <= CORE_WAIT;
                end
                CORE_WAIT: begin
                    // A result arriving on the expiry cycle still wins.
                    if (core_valid) begin
                        res_reg <= core_res;
                        ch_idx  <= '0;
                        state   <= TO_FLT;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        out_err   <= 1'b1;
                        out_z     <= {NCH{QNAN}};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                TO_FLT: begin
                    out_z[int'(ch_idx)*32 +: 32] <= cur_flt;
                    if (ch_idx == CH_W'(NCH - 1)) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        ch_idx <= ch_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ieee_fx_bridge.sv
// Randomised self-checking bench for ieee_fx_bridge against a real-arithmetic
// reference model of both conversions.
module tb_ieee_fx_bridge;

    localparam int W   = 32;
    localparam int F   = 16;
    localparam int NCH = 3;
    localparam int TMO = 8;
    localparam logic [31:0] QNAN_C = 32'h7FC0_0000;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        in_x;
    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       core_x;
    logic               core_en;
    logic [NCH*W-1:0]   core_res;
    logic               core_valid;
    logic [NCH*32-1:0]  out_z;
    logic               out_valid;
    logic               out_ready;
    logic               out_sat;
    logic               out_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [31:0] exp_q[$];

    ieee_fx_bridge #(
        .WIDTH     (W),
        .FRAC_BITS (F),
        .NCH       (NCH),
        .TIMEOUT   (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_x       (in_x),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .core_x     (core_x),
        .core_en    (core_en),
        .core_res   (core_res),
        .core_valid (core_valid),
        .out_z      (out_z),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sat    (out_sat),
        .out_err    (out_err)
    );

    // clock / reset-independent cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic real pow2(input int n);
        real r;
        r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else        for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    // Reference: float value times 2^F, truncated toward zero, saturating.
    task automatic ref_to_fix(input logic [31:0] x, output logic [31:0] fx, output logic sat);
        int  e;
        real mag;
        int  q;
        e   = int'(x[30:23]);
        sat = 1'b0;
        fx  = '0;
        if (e != 0) begin
            mag = (1.0 + real'(x[22:0]) / 8388608.0) * pow2(e - 127);
            if (e == 255 || mag >= pow2(W - 1 - F)) begin
                sat = 1'b1;
                fx  = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else begin
                q  = $rtoi(mag * pow2(F));
                fx = x[31] ? 32'(-q) : 32'(q);
            end
        end
    endtask

    // Reference: real value v/2^F rounded to single precision, nearest-even.
    function automatic logic [31:0] ref_to_flt(input logic [31:0] v);
        longint a;
        int     p;
        real    xs;
        real    fl;
        real    diff;
        longint m;
        int     ex;
        if (v == 32'h0) return 32'h0;
        a = v[31] ? (64'sh1_0000_0000 - longint'(v)) : longint'(v);
        p = 0;
        while ((a >> (p + 1)) != 0) p++;
        xs   = real'(a) * pow2(23 - p);
        fl   = $floor(xs);
        m    = longint'(fl);
        diff = xs - fl;
        if (diff > 0.5 || (diff == 0.5 && m[0])) m++;
        if (m == 64'd16777216) begin
            m = 64'd8388608;
            p++;
        end
        ex = p - F + 127;
        return {v[31], 8'(ex), m[22:0]};
    endfunction

    task automatic run_txn(input logic [31:0] x, input logic [NCH*W-1:0] res,
                           input int lat, input bit hang, input int hold);
        logic [31:0] efx;
        logic        esat;
        logic [31:0] exp_ch[NCH];
        int          t0;
        bit          seen;
        ref_to_fix(x, efx, esat);
        for (int k = 0; k < NCH; k++)
            exp_q.push_back(hang ? QNAN_C : ref_to_flt(res[k*W +: W]));
        for (int k = 0; k < NCH; k++) exp_ch[k] = exp_q.pop_front();

        check_eq("in_ready_idle", 32'(in_ready), 32'd1);
        in_x     = x;
        in_valid = 1'b1;
        t0       = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        in_x     = $urandom;
        check_eq("flags_clear_on_accept", {30'd0, out_sat, out_err}, 32'd0);
        check_eq("in_ready_busy", 32'(in_ready), 32'd0);

        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (core_en) seen = 1'b1;
            else @(negedge clk);
        end
        check_eq("core_en_seen", 32'(seen), 32'd1);
        check_eq("core_x", core_x, efx);
        @(negedge clk);
        check_eq("core_en_one_cycle", 32'(core_en), 32'd0);

        if (!hang) begin
            for (int i = 0; i < lat - 1; i++) @(negedge clk);
            core_res   = res;
            core_valid = 1'b1;
            @(negedge clk);
            core_valid = 1'b0;
            core_res   = {NCH{$urandom}};
        end

        seen = 1'b0;
        for (int i = 0; i < TMO + 40 && !seen; i++) begin
            if (out_valid) seen = 1'b1;
            else @(negedge clk);
        end
        check_eq("out_valid_seen", 32'(seen), 32'd1);
        check_eq("latency", 32'(cyc - t0), hang ? 32'(TMO + 3) : 32'(3 + lat + NCH));
        for (int k = 0; k < NCH; k++) check_eq($sformatf("out_z_ch%0d", k), out_z[k*32 +: 32], exp_ch[k]);
        check_eq("out_sat", 32'(out_sat), 32'(esat));
        check_eq("out_err", 32'(out_err), 32'(hang));

        // Back-pressure with a competing operand and a stray core_valid.
        for (int i = 0; i < hold; i++) begin
            in_valid   = 1'b1;
            core_valid = 1'b1;
            core_res   = {NCH{$urandom}};
            @(negedge clk);
            check_eq("hold_in_ready", 32'(in_ready), 32'd0);
            check_eq("hold_out_valid", 32'(out_valid), 32'd1);
            for (int k = 0; k < NCH; k++) check_eq("hold_out_z", out_z[k*32 +: 32], exp_ch[k]);
            check_eq("hold_flags", {30'd0, out_sat, out_err}, {30'd0, esat, hang});
        end
        in_valid   = 1'b0;
        core_valid = 1'b0;
        out_ready  = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("release_out_valid", 32'(out_valid), 32'd0);
        check_eq("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    function automatic logic [31:0] rand_float();
        logic [7:0] e;
        case ($urandom_range(0, 9))
            0:       e = 8'd0;
            1:       e = 8'd255;
            default: e = 8'($urandom_range(100, 145));
        endcase
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'($urandom_range(0, 255));
            3:       return {8'h01, 22'h0, 2'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [NCH*W-1:0] res;
        bit               stray;
        rst        = 1'b1;
        in_x       = '0;
        in_valid   = 1'b0;
        core_res   = '0;
        core_valid = 1'b0;
        out_ready  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_core_en", 32'(core_en), 32'd0);
        check_eq("rst_core_x", core_x, 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_flags", {30'd0, out_sat, out_err}, 32'd0);
        for (int k = 0; k < NCH; k++) check_eq("rst_out_z", out_z[k*32 +: 32], 32'd0);

        // Directed operands and rounding corners.
        res = {32'h0100_0001, 32'h1234_5678, 32'h0002_B7E1};
        run_txn(32'h3F80_0000, res, 2, 1'b0, 0);
        res = {32'h0100_0001, 32'h8000_0000, 32'h0000_0001};
        run_txn(32'hC020_0000, res, 1, 1'b0, 0);
        res = {32'h0100_0003, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        run_txn(32'h4974_2400, res, 3, 1'b0, 5);
        res = {32'h0000_0000, 32'h00FF_FFFF, 32'hFF00_0001};
        run_txn(32'hFF80_0000, res, 4, 1'b0, 0);
        run_txn(32'h7FC0_0000, res, 1, 1'b0, 1);
        run_txn(32'hFFC0_0001, res, 1, 1'b0, 0);
        run_txn(32'h3F80_0000, res, 1, 1'b1, 2);
        run_txn(32'h0000_1234, res, 2, 1'b0, 0);

        // Reset while waiting on the core abandons the transaction.
        in_x     = 32'h3F80_0000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_core_en", 32'(core_en), 32'd0);
        stray = 1'b0;
        for (int i = 0; i < TMO + 10; i++) begin
            @(negedge clk);
            if (out_valid || core_en) stray = 1'b1;
        end
        check_eq("midrst_no_output", 32'(stray), 32'd0);

        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < NCH; k++) res[k*W +: W] = rand_word();
            run_txn(rand_float(), res, $urandom_range(1, 6), ($urandom_range(0, 9) == 0), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected $finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
